// File: rtl/sevenseg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment display blocks.
package sevenseg_scan_pkg;

   localparam int NUM_DIGITS = 4;

   // All segments off (active-low).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Bit positions inside a {g,f,e,d,c,b,a} segment vector.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Active-low hex glyphs, indexed by nibble value.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/sevenseg_scan_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_7seg
   import sevenseg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Straight table lookup; glyphs live in the shared package.
   always_comb begin
      seg_n = HEX_SEG[nibble];
   end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver with frame-aligned updates.
module sevenseg_scan
   import sevenseg_scan_pkg::*;
#(
   parameter int DIV_COUNT = 100000,
   parameter bit LZ_BLANK  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value_in,
   input  logic        load,
   input  logic [3:0]  dp_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_pulse
);

   localparam int              CNT_W    = $clog2(DIV_COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       idx_reg;
   logic [15:0]      disp_val_reg;
   logic [3:0]       disp_dp_reg;
   logic [15:0]      pend_val_reg;
   logic [3:0]       pend_dp_reg;
   logic             pending_reg;
   logic             frame_pulse_reg;
   logic [6:0]       seg_reg;
   logic             dp_reg;
   logic [3:0]       an_reg;

   logic             tick;
   logic             boundary;
   logic [3:0]       blank_vec;
   logic [3:0]       nibble_sel;
   logic [6:0]       seg_dec;

   assign tick     = (cnt_reg == CNT_LAST);
   assign boundary = tick && (idx_reg == 2'd3);

   // Leading-zero blanking: digit k>0 goes dark when it and every digit
   // above it are zero, unless its decimal point is lit.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
         if (gi == 0) begin : g_first
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = LZ_BLANK &&
                                   (disp_val_reg[15:gi*4] == '0) &&
                                   !disp_dp_reg[gi];
         end
      end
   endgenerate

   assign nibble_sel = disp_val_reg[{idx_reg, 2'b00} +: 4];

   hex_to_7seg u_hex_to_7seg (
      .nibble (nibble_sel),
      .seg_n  (seg_dec)
   );

   // Slot prescaler and digit index; index steps once per slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
         idx_reg <= 2'd0;
      end else begin
         if (tick) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   // Shadow register: loads park in pend_* and are committed only at a
   // frame boundary; a load on the boundary itself goes straight through.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_val_reg    <= '0;
         disp_dp_reg     <= '0;
         pend_val_reg    <= '0;
         pend_dp_reg     <= '0;
         pending_reg     <= 1'b0;
         frame_pulse_reg <= 1'b0;
      end else begin
         frame_pulse_reg <= boundary;
         if (boundary) begin
            pending_reg <= 1'b0;
            if (load) begin
               disp_val_reg <= value_in;
               disp_dp_reg  <= dp_in;
            end else if (pending_reg) begin
               disp_val_reg <= pend_val_reg;
               disp_dp_reg  <= pend_dp_reg;
            end
         end else if (load) begin
            pend_val_reg <= value_in;
            pend_dp_reg  <= dp_in;
            pending_reg  <= 1'b1;
         end
      end
   end

   // Registered drive of anodes/segments for the currently indexed digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_reg  <= 4'hF;
         seg_reg <= SEG_BLANK;
         dp_reg  <= 1'b1;
      end else if (blank_vec[idx_reg]) begin
         an_reg  <= 4'hF;
         seg_reg <= SEG_BLANK;
         dp_reg  <= 1'b1;
      end else begin
         an_reg  <= ~(4'b0001 << idx_reg);
         seg_reg <= seg_dec;
         dp_reg  <= ~disp_dp_reg[idx_reg];
      end
   end

   assign seg         = seg_reg;
   assign dp          = dp_reg;
   assign an          = an_reg;
   assign frame_pulse = frame_pulse_reg;

endmodule
